// File: rtl/axis_pkg.sv
// Shared types and helpers for the AXI-Stream packet FIFO.
// Holds the pointer-width rule, the write FSM encoding and the tuser error-bit position.
package axis_pkg;

  // Pointers carry one extra bit so that full and empty can be told apart.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef enum logic {
    ACCEPT = 1'b0,
    DROP   = 1'b1
  } wr_state_t;

  localparam int USER_ERR_BIT = 0;

endpackage

// File: rtl/axis_fifo_ram.sv
// Simple dual-port beat store: synchronous write, asynchronous read.
// The storage has no reset so that it can map onto block or distributed RAM.
module axis_fifo_ram #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/axis_packet_fifo.sv
// Store-and-forward AXI-Stream packet FIFO: a packet is released only after a clean tlast,
// and bad or oversize packets are rewound away so that no partial packet is ever emitted.
module axis_packet_fifo
  import axis_pkg::*;
#(
  parameter int AXIS_BYTES     = 1,
  parameter int AXIS_USER_BITS = 1,
  parameter int DEPTH          = 16
) (
  input  logic                       clk,
  input  logic                       areset,
  output logic                       axis_i_tready,
  input  logic                       axis_i_tvalid,
  input  logic                       axis_i_tlast,
  input  logic [AXIS_BYTES*8-1:0]    axis_i_tdata,
  input  logic [AXIS_USER_BITS-1:0]  axis_i_tuser,
  input  logic                       axis_o_tready,
  output logic                       axis_o_tvalid,
  output logic                       axis_o_tlast,
  output logic [AXIS_BYTES*8-1:0]    axis_o_tdata,
  output logic [AXIS_USER_BITS-1:0]  axis_o_tuser,
  output logic                       drop_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int PW = ptr_width(DEPTH);
  localparam int AW = PW - 1;
  localparam int DB = AXIS_BYTES * 8;
  localparam int DW = 1 + AXIS_USER_BITS + DB;

  wr_state_t state, state_nxt;
  logic [PW-1:0] wr_ptr, commit_ptr, rd_ptr;
  logic [PW-1:0] wr_ptr_nxt, commit_nxt;
  logic [PW-1:0] used;
  logic          full, oversize, in_hs, in_err, wr_en, drop_nxt, rd_load;
  logic [DW-1:0] wdata, rdata;

  assign used     = wr_ptr - rd_ptr;
  assign full     = (used == PW'(DEPTH));
  // Full with nothing committed: the open packet can never fit, so it is dropped.
  assign oversize = full && (commit_ptr == rd_ptr);
  assign level_o  = used;

  // Oversize keeps tready high so the discarded beats keep flowing into DROP.
  always_comb begin
    axis_i_tready = 1'b0;
    if (!areset) begin
      if (state == DROP) axis_i_tready = 1'b1;
      else               axis_i_tready = !full || oversize;
    end
  end

  assign in_hs  = axis_i_tvalid && axis_i_tready;
  assign in_err = axis_i_tuser[USER_ERR_BIT];
  assign wr_en  = (state == ACCEPT) && in_hs && !full;
  assign wdata  = {axis_i_tlast, axis_i_tuser, axis_i_tdata};

  always_comb begin
    state_nxt  = state;
    wr_ptr_nxt = wr_ptr;
    commit_nxt = commit_ptr;
    drop_nxt   = 1'b0;
    case (state)
      ACCEPT: begin
        if (oversize) begin
          wr_ptr_nxt = commit_ptr;
          drop_nxt   = 1'b1;
          if (!(in_hs && axis_i_tlast)) state_nxt = DROP;
        end else if (wr_en) begin
          if (axis_i_tlast && in_err) begin
            wr_ptr_nxt = commit_ptr;
            drop_nxt   = 1'b1;
          end else begin
            wr_ptr_nxt = wr_ptr + 1'b1;
            if (axis_i_tlast) commit_nxt = wr_ptr + 1'b1;
          end
        end
      end
      DROP: begin
        if (in_hs && axis_i_tlast) state_nxt = ACCEPT;
      end
      default: state_nxt = ACCEPT;
    endcase
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state      <= ACCEPT;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      drop_o     <= 1'b0;
    end else begin
      state      <= state_nxt;
      wr_ptr     <= wr_ptr_nxt;
      commit_ptr <= commit_nxt;
      drop_o     <= drop_nxt;
    end
  end

  axis_fifo_ram #(
    .WIDTH (DW),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (wdata),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rdata)
  );

  assign rd_load = (rd_ptr != commit_ptr) && (!axis_o_tvalid || axis_o_tready);

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      rd_ptr        <= '0;
      axis_o_tvalid <= 1'b0;
      axis_o_tlast  <= 1'b0;
      axis_o_tuser  <= '0;
      axis_o_tdata  <= '0;
    end else if (rd_load) begin
      rd_ptr        <= rd_ptr + 1'b1;
      axis_o_tvalid <= 1'b1;
      axis_o_tlast  <= rdata[DW-1];
      axis_o_tuser  <= rdata[DB +: AXIS_USER_BITS];
      axis_o_tdata  <= rdata[DB-1:0];
    end else if (axis_o_tready) begin
      axis_o_tvalid <= 1'b0;
    end
  end

endmodule
